// File: rtl/count_stim_pkg.sv
// Shared types and helpers for the count_stim_driver block.
// Optional shadow counters in prescale_tracker are built when SHADOW_CNT_EN is defined.
package count_stim_pkg;

    localparam int unsigned PRESCALE = 4;
    localparam int unsigned PHASE_W  = 2;
    localparam int unsigned CALC_W   = 34;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Driven cycles needed to advance the chosen channel by n, given the prescaler phase.
    function automatic logic [CALC_W-1:0] calc_cycles(
        input logic               ch,
        input logic [CALC_W-3:0]  n,
        input logic [PHASE_W-1:0] phase
    );
        logic [CALC_W-1:0] k;
        if (!ch) begin
            k = CALC_W'(n);
        end else if (n == '0) begin
            k = '0;
        end else begin
            k = (CALC_W'(n) * CALC_W'(PRESCALE)) - CALC_W'(phase);
        end
        return k;
    endfunction

endpackage

// File: rtl/count_stim_driver_prescale_tracker.sv
// Shadow of the downstream counter's channel-1 prescaler phase.
// With SHADOW_CNT_EN defined, also mirrors both downstream output counters.
module prescale_tracker
    import count_stim_pkg::*;
(
    input  logic               Clk,
    input  logic               Reset,
    input  logic               en_i,
    input  logic               slt_i,
    output logic [PHASE_W-1:0] phase_o
`ifdef SHADOW_CNT_EN
    ,
    output logic [63:0]        shadow0_o,
    output logic [63:0]        shadow1_o
`endif
);

    logic [PHASE_W-1:0] phase_q;

    // Phase advances on the same edge the counter sees En&&Slt.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            phase_q <= '0;
        end else if (en_i && slt_i) begin
            phase_q <= phase_q + PHASE_W'(1);
        end
    end

    assign phase_o = phase_q;

`ifdef SHADOW_CNT_EN
    logic [63:0] shadow0_q;
    logic [63:0] shadow1_q;

    // Output1 ticks when the prescaler wraps from its last phase.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            shadow0_q <= '0;
            shadow1_q <= '0;
        end else begin
            if (en_i && !slt_i) begin
                shadow0_q <= shadow0_q + 64'(1);
            end
            if (en_i && slt_i && (phase_q == PHASE_W'(PRESCALE - 1))) begin
                shadow1_q <= shadow1_q + 64'(1);
            end
        end
    end

    assign shadow0_o = shadow0_q;
    assign shadow1_o = shadow1_q;
`endif

endmodule

// File: rtl/count_stim_driver.sv
// Initiator for the dual-channel En/Slt event counter: turns "advance channel C by N" commands
// into exact En/Slt pulse trains. SHADOW_CNT_EN adds Shadow0/Shadow1 mirror outputs.
module count_stim_driver
    import count_stim_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_ch,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic             Hold,
    output logic             En,
    output logic             Slt,
    output logic             busy,
    output logic             done
`ifdef SHADOW_CNT_EN
    ,
    output logic [63:0]      Shadow0,
    output logic [63:0]      Shadow1
`endif
);

    localparam int unsigned K_W = CNT_W + 2;

    state_e             state_q, state_d;
    logic               ch_q, ch_d;
    logic [K_W-1:0]     rem_q, rem_d;
    logic               en_q, en_d;
    logic               slt_q, slt_d;
    logic               done_q, done_d;
    logic               busy_q;
    logic [PHASE_W-1:0] phase;
    logic [K_W-1:0]     k_c;

    assign k_c = K_W'(calc_cycles(cmd_ch, (CALC_W-2)'(cmd_count), phase));

    // State register; En/Slt/done are registered alongside so they line up with the state.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            ch_q    <= 1'b0;
            rem_q   <= '0;
            en_q    <= 1'b0;
            slt_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            rem_q   <= rem_d;
            en_q    <= en_d;
            slt_q   <= slt_d;
            done_q  <= done_d;
            busy_q  <= (state_d == DRIVE);
        end
    end

    // rem_q counts cycles not yet committed to En; the decision for the next cycle uses Hold now.
    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        rem_d   = rem_q;
        en_d    = 1'b0;
        slt_d   = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    ch_d = cmd_ch;
                    if (k_c == '0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        rem_d   = '0;
                    end else begin
                        state_d = DRIVE;
                        if (!Hold) begin
                            en_d  = 1'b1;
                            slt_d = cmd_ch;
                            rem_d = k_c - K_W'(1);
                        end else begin
                            rem_d = k_c;
                        end
                    end
                end
            end
            DRIVE: begin
                if (rem_q == '0) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else if (!Hold) begin
                    en_d  = 1'b1;
                    slt_d = ch_q;
                    rem_d = rem_q - K_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    prescale_tracker u_prescale_tracker (
        .Clk       (Clk),
        .Reset     (Reset),
        .en_i      (en_q),
        .slt_i     (slt_q),
        .phase_o   (phase)
`ifdef SHADOW_CNT_EN
        ,
        .shadow0_o (Shadow0),
        .shadow1_o (Shadow1)
`endif
    );

    assign cmd_ready = (state_q == IDLE);
    assign En        = en_q;
    assign Slt       = slt_q;
    assign done      = done_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_count_stim_driver.sv
// Self-checking bench for count_stim_driver against a model of the downstream counter.
module tb_count_stim_driver;

    localparam int unsigned CNT_W = 16;

    logic             Clk;
    logic             Reset;
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_ch;
    logic [CNT_W-1:0] cmd_count;
    logic             Hold;
    logic             En;
    logic             Slt;
    logic             busy;
    logic             done;
`ifdef SHADOW_CNT_EN
    logic [63:0]      Shadow0;
    logic [63:0]      Shadow1;
`endif

    int tests = 0;
    int fails = 0;

    // Downstream counter model and expected totals derived from the commands issued.
    logic [63:0] m_out0, m_out1;
    logic [1:0]  m_pre;
    longint      exp_out0, exp_out1;

    count_stim_driver #(.CNT_W(CNT_W)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_ch    (cmd_ch),
        .cmd_count (cmd_count),
        .Hold      (Hold),
        .En        (En),
        .Slt       (Slt),
        .busy      (busy),
        .done      (done)
`ifdef SHADOW_CNT_EN
        ,
        .Shadow0   (Shadow0),
        .Shadow1   (Shadow1)
`endif
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    always @(posedge Clk) begin
        if (Reset) begin
            m_out0 <= '0;
            m_out1 <= '0;
            m_pre  <= '0;
        end else if (En) begin
            if (!Slt) begin
                m_out0 <= m_out0 + 64'd1;
            end else begin
                if (m_pre == 2'd3) m_out1 <= m_out1 + 64'd1;
                m_pre <= m_pre + 2'd1;
            end
        end
    end

    task automatic check_idle_outputs(input string tag);
        tests++;
        if (En !== 1'b0 || Slt !== 1'b0 || done !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
            fails++;
            $display("FAIL %s: En=%b Slt=%b done=%b busy=%b ready=%b required 0 0 0 0 1",
                     tag, En, Slt, done, busy, cmd_ready);
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        repeat (2) @(negedge Clk);
        check_idle_outputs("reset_held");
        Reset = 1'b0;
        exp_out0 = 0;
        exp_out1 = 0;
        @(negedge Clk);
        check_idle_outputs("reset_released");
`ifdef SHADOW_CNT_EN
        tests++;
        if (Shadow0 !== 64'd0 || Shadow1 !== 64'd0) begin
            fails++;
            $display("FAIL reset_shadow: Shadow0=%0d Shadow1=%0d required 0 0", Shadow0, Shadow1);
        end
`endif
    endtask

    // Issue one command and check its timing, pulse count and resulting counter values.
    task automatic run_cmd(input logic ch, input int n, input int hold_at, input int hold_len,
                           input string tag);
        int k, en_cnt, done_c, hold_left, eff_hold, exp_done, w;
        bit hold_used;
        w = 0;
        while (cmd_ready !== 1'b1 && w < 20) begin
            @(negedge Clk);
            w++;
        end
        tests++;
        if (cmd_ready !== 1'b1) begin
            fails++;
            $display("FAIL %s ready_wait: cmd_ready=%b required 1", tag, cmd_ready);
        end
        k = (ch == 1'b0) ? n : ((n == 0) ? 0 : 4 * n - int'(m_pre));
        eff_hold = (hold_at > 0 && hold_at < k) ? hold_len : 0;
        exp_done = k + 1 + eff_hold;
        cmd_valid = 1'b1;
        cmd_ch    = ch;
        cmd_count = 16'(n);
        en_cnt    = 0;
        done_c    = -1;
        hold_left = 0;
        hold_used = 1'b0;
        for (int c = 1; c <= exp_done + 8 && done_c < 0; c++) begin
            @(negedge Clk);
            cmd_valid = 1'b0;
            if (En === 1'b1) en_cnt++;
            tests++;
            if (Slt !== ((En === 1'b1) ? ch : 1'b0)) begin
                fails++;
                $display("FAIL %s slt_c%0d: En=%b Slt=%b required Slt=%b", tag, c, En, Slt,
                         (En === 1'b1) ? ch : 1'b0);
            end
            tests++;
            if (busy !== ((k != 0) && (c < exp_done))) begin
                fails++;
                $display("FAIL %s busy_c%0d: busy=%b required %b", tag, c, busy,
                         (k != 0) && (c < exp_done));
            end
`ifdef SHADOW_CNT_EN
            tests++;
            if (Shadow0 !== m_out0 || Shadow1 !== m_out1) begin
                fails++;
                $display("FAIL %s shadow_c%0d: Shadow0=%0d Shadow1=%0d required %0d %0d",
                         tag, c, Shadow0, Shadow1, m_out0, m_out1);
            end
`endif
            if (done === 1'b1) done_c = c;
            if (hold_left > 0) begin
                hold_left--;
                if (hold_left == 0) Hold = 1'b0;
            end else if (eff_hold > 0 && en_cnt == hold_at && !hold_used) begin
                Hold      = 1'b1;
                hold_left = eff_hold;
                hold_used = 1'b1;
            end
        end
        Hold = 1'b0;
        tests++;
        if (done_c != exp_done) begin
            fails++;
            $display("FAIL %s done_cycle: got T+%0d required T+%0d", tag, done_c, exp_done);
        end
        tests++;
        if (en_cnt != k) begin
            fails++;
            $display("FAIL %s en_count: got %0d required %0d", tag, en_cnt, k);
        end
        @(negedge Clk);
        tests++;
        if (done !== 1'b0 || cmd_ready !== 1'b1) begin
            fails++;
            $display("FAIL %s after_done: done=%b ready=%b required 0 1", tag, done, cmd_ready);
        end
        if (ch == 1'b0) exp_out0 += n;
        else            exp_out1 += n;
        tests++;
        if (m_out0 !== 64'(exp_out0) || m_out1 !== 64'(exp_out1)) begin
            fails++;
            $display("FAIL %s outputs: Output0=%0d Output1=%0d required %0d %0d",
                     tag, m_out0, m_out1, exp_out0, exp_out1);
        end
        if (ch == 1'b1 && n > 0) begin
            tests++;
            if (m_pre !== 2'd0) begin
                fails++;
                $display("FAIL %s phase_end: phase=%0d required 0", tag, m_pre);
            end
        end
    endtask

    task automatic test_ch0_basic();
        run_cmd(1'b0, 5, 0, 0, "ch0_n5");
    endtask

    task automatic test_ch1_basic();
        run_cmd(1'b1, 2, 0, 0, "ch1_n2");
    endtask

    task automatic test_mixed_after_reset();
        test_reset();
        run_cmd(1'b1, 1, 0, 0, "ch1_n1");
        run_cmd(1'b0, 3, 0, 0, "ch0_n3_after_ch1");
    endtask

    task automatic test_zero_count();
        run_cmd(1'b1, 0, 0, 0, "ch1_n0");
        run_cmd(1'b0, 0, 0, 0, "ch0_n0");
    endtask

    task automatic test_hold();
        run_cmd(1'b0, 6, 2, 3, "ch0_n6_hold");
        run_cmd(1'b1, 2, 5, 2, "ch1_n2_hold");
    endtask

    task automatic test_reset_mid_command();
        int en_cnt = 0;
        int c = 0;
        cmd_valid = 1'b1;
        cmd_ch    = 1'b1;
        cmd_count = 16'd4;
        @(negedge Clk);
        cmd_valid = 1'b0;
        if (En === 1'b1) en_cnt++;
        while (en_cnt < 3 && c < 20) begin
            @(negedge Clk);
            c++;
            if (En === 1'b1) en_cnt++;
        end
        tests++;
        if (en_cnt != 3) begin
            fails++;
            $display("FAIL mid_reset_reach: driven=%0d required 3", en_cnt);
        end
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        exp_out0 = 0;
        exp_out1 = 0;
        check_idle_outputs("mid_reset");
        run_cmd(1'b1, 1, 0, 0, "ch1_n1_after_mid_reset");
    endtask

    task automatic test_cmd_during_reset();
        Reset     = 1'b1;
        cmd_valid = 1'b1;
        cmd_ch    = 1'b0;
        cmd_count = 16'd5;
        @(negedge Clk);
        Reset     = 1'b0;
        cmd_valid = 1'b0;
        exp_out0  = 0;
        exp_out1  = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            check_idle_outputs("cmd_in_reset_ignored");
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 30; i++) begin
            logic ch;
            int n, ha, hl;
            ch = 1'($urandom_range(0, 1));
            n  = int'($urandom_range(0, 12));
            ha = int'($urandom_range(0, 8));
            hl = int'($urandom_range(0, 3));
            run_cmd(ch, n, ha, hl, "random");
        end
    endtask

    initial begin
        Reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_ch    = 1'b0;
        cmd_count = '0;
        Hold      = 1'b0;
        exp_out0  = 0;
        exp_out1  = 0;
        @(negedge Clk);
        test_reset();
        test_ch0_basic();
        test_ch1_basic();
        test_mixed_after_reset();
        test_zero_count();
        test_hold();
        test_reset_mid_command();
        test_cmd_during_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
